// File: rtl/pps_uart_reporter.sv
// Turns every REPORT_DIV-th enabled pps strobe into an ASCII "T<hex4>[CR]LF" frame on a UART byte stream.
// Optional CR before LF is compiled in when REPORTER_CRLF_EN is defined.
module pps_uart_reporter #(
  parameter logic [7:0] REPORT_DIV  = 8'd1,
  parameter logic [7:0] HEADER_CHAR = 8'h54
) (
  input  logic        clk_50m,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        pps,
  input  logic [15:0] second,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        busy,
  output logic [7:0]  overrun_cnt
);

  localparam int unsigned SEC_W  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ST_W   = 3;

  localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
  localparam logic [ST_W-1:0] ST_HDR  = 3'd1;
  localparam logic [ST_W-1:0] ST_DIG  = 3'd2;
  localparam logic [ST_W-1:0] ST_LF   = 3'd3;
`ifdef REPORTER_CRLF_EN
  localparam logic [ST_W-1:0] ST_CR   = 3'd4;
`endif

  logic [ST_W-1:0]   state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [SEC_W-1:0]  snap_q, snap_d;
  logic [BYTE_W-1:0] div_cnt_q, div_cnt_d;
  logic [BYTE_W-1:0] overrun_d;
  logic [BYTE_W-1:0] tx_data_d;
  logic              pps_en;
  logic              report;
  logic              handshake;

  function automatic logic [BYTE_W-1:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + 8'(nib);
    else             return 8'h37 + 8'(nib);
  endfunction

  // Next-state, divider, overrun and next output byte
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    div_cnt_d = div_cnt_q;
    overrun_d = overrun_cnt;
    tx_data_d = 8'h00;
    pps_en    = pps && enable;
    report    = pps_en && (div_cnt_q == (REPORT_DIV - 8'd1));
    handshake = tx_valid && tx_ready;

    if (pps_en) div_cnt_d = report ? 8'd0 : div_cnt_q + 8'd1;

    case (state_q)
      ST_IDLE: begin
        if (report) begin
          state_d = ST_HDR;
          snap_d  = second;
        end
      end
      ST_HDR: begin
        if (handshake) begin
          state_d = ST_DIG;
          idx_d   = 2'd3;
        end
      end
      ST_DIG: begin
        if (handshake) begin
          if (idx_q == 2'd0) begin
`ifdef REPORTER_CRLF_EN
            state_d = ST_CR;
`else
            state_d = ST_LF;
`endif
          end else begin
            idx_d = idx_q - 2'd1;
          end
        end
      end
`ifdef REPORTER_CRLF_EN
      ST_CR: begin
        if (handshake) state_d = ST_LF;
      end
`endif
      ST_LF: begin
        if (handshake) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A report strobe that finds a frame in flight (including the LF handshake cycle) is dropped
    if (report && (state_q != ST_IDLE) && (overrun_cnt != 8'hFF))
      overrun_d = overrun_cnt + 8'd1;

    case (state_d)
      ST_HDR:  tx_data_d = HEADER_CHAR;
      ST_DIG:  tx_data_d = hex_ascii(snap_d[{idx_d, 2'b00} +: 4]);
`ifdef REPORTER_CRLF_EN
      ST_CR:   tx_data_d = 8'h0D;
`endif
      ST_LF:   tx_data_d = 8'h0A;
      default: tx_data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= 2'd0;
      snap_q      <= '0;
      div_cnt_q   <= '0;
      overrun_cnt <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      div_cnt_q   <= div_cnt_d;
      overrun_cnt <= overrun_d;
      tx_data     <= tx_data_d;
      tx_valid    <= (state_d != ST_IDLE);
      busy        <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_pps_uart_reporter.sv
// Directed bench for pps_uart_reporter: frame contents, stalls, divider, overrun, reset and enable.
// Expects CR in the frame when REPORTER_CRLF_EN is defined.
module tb_pps_uart_reporter;

`ifdef REPORTER_CRLF_EN
  localparam int FRAME_LEN = 7;
`else
  localparam int FRAME_LEN = 6;
`endif

  logic        clk_50m;
  logic        reset_n;
  logic        enable;
  logic        pps;
  logic        pps3;
  logic [15:0] second;
  logic        tx_ready;
  logic [7:0]  tx_data,  tx_data3;
  logic        tx_valid, tx_valid3;
  logic        busy,     busy3;
  logic [7:0]  overrun_cnt, overrun_cnt3;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] lfsr = 16'hACE1;
  logic [7:0]  q3[$];

  pps_uart_reporter #(.REPORT_DIV(8'd1), .HEADER_CHAR(8'h54)) dut (
    .clk_50m(clk_50m), .reset_n(reset_n), .enable(enable), .pps(pps), .second(second),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy),
    .overrun_cnt(overrun_cnt)
  );

  pps_uart_reporter #(.REPORT_DIV(8'd3), .HEADER_CHAR(8'h54)) dut3 (
    .clk_50m(clk_50m), .reset_n(reset_n), .enable(enable), .pps(pps3), .second(second),
    .tx_ready(tx_ready), .tx_data(tx_data3), .tx_valid(tx_valid3), .busy(busy3),
    .overrun_cnt(overrun_cnt3)
  );

  initial clk_50m = 1'b0;
  always #10 clk_50m = ~clk_50m;

  // Bytes accepted by the divide-by-3 instance
  always @(posedge clk_50m) if (tx_valid3 && tx_ready) q3.push_back(tx_data3);

  function automatic logic [0:6][7:0] mk(input logic [7:0] b0, b1, b2, b3, b4);
`ifdef REPORTER_CRLF_EN
    return {b0, b1, b2, b3, b4, 8'h0D, 8'h0A};
`else
    return {b0, b1, b2, b3, b4, 8'h0A, 8'h00};
`endif
  endfunction

  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    pps = 1'b0;
    pps3 = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic start_report(input logic [15:0] sec);
    pps = 1'b1;
    second = sec;
    tick();
    pps = 1'b0;
  endtask

  // Called with the header byte already presented; consumes the whole frame
  task automatic check_frame(input logic [0:6][7:0] exp, input bit rnd, input string nm);
    int i = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [7:0] held = 8'h00;
    while (i < FRAME_LEN && cyc < 400) begin
      if (rnd) begin
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        tx_ready = lfsr[0];
      end else begin
        tx_ready = 1'b1;
      end
      n_tests++;
      if (tx_valid !== 1'b1 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s valid/busy byte %0d: got %b/%b exp 1/1", nm, i, tx_valid, busy);
      end
      if (stalled) begin
        n_tests++;
        if (tx_data !== held) begin
          n_fail++;
          $display("FAIL %s stall hold byte %0d: got %h exp %h", nm, i, tx_data, held);
        end
      end
      if (tx_ready) begin
        n_tests++;
        if (tx_data !== exp[i]) begin
          n_fail++;
          $display("FAIL %s byte %0d: got %h exp %h", nm, i, tx_data, exp[i]);
        end
        i++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = tx_data;
      end
      tick();
      cyc++;
    end
    tx_ready = 1'b1;
    n_tests++;
    if (i != FRAME_LEN) begin
      n_fail++;
      $display("FAIL %s timeout: got %0d bytes exp %0d", nm, i, FRAME_LEN);
    end
    if (!rnd) begin
      n_tests++;
      if (cyc != FRAME_LEN) begin
        n_fail++;
        $display("FAIL %s frame cycles: got %0d exp %0d", nm, cyc, FRAME_LEN);
      end
    end
    n_tests++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle after frame: got busy=%b valid=%b exp 0/0", nm, busy, tx_valid);
    end
  endtask

  task automatic test_reset();
    #5;
    n_tests++;
    if (tx_data !== 8'h00 || tx_valid !== 1'b0 || busy !== 1'b0 || overrun_cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: got data=%h valid=%b busy=%b ovr=%h exp 00/0/0/00",
               tx_data, tx_valid, busy, overrun_cnt);
    end
    n_tests++;
    if (tx_valid3 !== 1'b0 || busy3 !== 1'b0 || overrun_cnt3 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state_div3: got valid=%b busy=%b ovr=%h exp 0/0/00",
               tx_valid3, busy3, overrun_cnt3);
    end
    apply_reset();
  endtask

  task automatic test_frame();
    start_report(16'h1A2F);
    check_frame(mk(8'h54, 8'h31, 8'h41, 8'h32, 8'h46), 1'b0, "frame_1A2F");
    start_report(16'h00FF);
    check_frame(mk(8'h54, 8'h30, 8'h30, 8'h46, 8'h46), 1'b0, "frame_00FF");
  endtask

  task automatic test_random_ready();
    tx_ready = 1'b0;
    start_report(16'h1A2F);
    check_frame(mk(8'h54, 8'h31, 8'h41, 8'h32, 8'h46), 1'b1, "rnd_ready_1A2F");
    start_report(16'hBEEF);
    check_frame(mk(8'h54, 8'h42, 8'h45, 8'h45, 8'h46), 1'b1, "rnd_ready_BEEF");
  endtask

  task automatic test_div3();
    logic [0:6][7:0] ea, eb;
    ea = mk(8'h54, 8'h30, 8'h30, 8'h30, 8'h33);
    eb = mk(8'h54, 8'h30, 8'h30, 8'h30, 8'h36);
    apply_reset();
    q3.delete();
    tx_ready = 1'b1;
    for (int s = 1; s <= 6; s++) begin
      pps3 = 1'b1;
      second = 16'(s);
      tick();
      pps3 = 1'b0;
      repeat (9) tick();
    end
    n_tests++;
    if (q3.size() != 2 * FRAME_LEN) begin
      n_fail++;
      $display("FAIL div3 byte count: got %0d exp %0d", q3.size(), 2 * FRAME_LEN);
    end else begin
      for (int k = 0; k < FRAME_LEN; k++) begin
        n_tests++;
        if (q3[k] !== ea[k]) begin
          n_fail++;
          $display("FAIL div3 frame0 byte %0d: got %h exp %h", k, q3[k], ea[k]);
        end
        n_tests++;
        if (q3[FRAME_LEN + k] !== eb[k]) begin
          n_fail++;
          $display("FAIL div3 frame1 byte %0d: got %h exp %h", k, q3[FRAME_LEN + k], eb[k]);
        end
      end
    end
    n_tests++;
    if (overrun_cnt3 !== 8'h00) begin
      n_fail++;
      $display("FAIL div3 overrun: got %h exp 00", overrun_cnt3);
    end
  endtask

  task automatic test_overrun();
    tx_ready = 1'b0;
    start_report(16'hBEEF);
    for (int k = 0; k < 300; k++) begin
      pps = 1'b1;
      second = 16'h1111;
      tick();
    end
    pps = 1'b0;
    n_tests++;
    if (overrun_cnt !== 8'hFF) begin
      n_fail++;
      $display("FAIL overrun saturate: got %h exp ff", overrun_cnt);
    end
    n_tests++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h54) begin
      n_fail++;
      $display("FAIL overrun stalled header: got valid=%b data=%h exp 1/54", tx_valid, tx_data);
    end
    check_frame(mk(8'h54, 8'h42, 8'h45, 8'h45, 8'h46), 1'b0, "overrun_BEEF");
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    tx_ready = 1'b1;
    start_report(16'h1A2F);
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (tx_data !== 8'h00 || tx_valid !== 1'b0 || busy !== 1'b0 || overrun_cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid async: got data=%h valid=%b busy=%b ovr=%h exp 00/0/0/00",
               tx_data, tx_valid, busy, overrun_cnt);
    end
    tick();
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (tx_valid) seen++;
      tick();
    end
    n_tests++;
    if (seen != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid no bytes: got %0d valid cycles busy=%b exp 0/0", seen, busy);
    end
  endtask

  task automatic test_enable();
    int seen = 0;
    apply_reset();
    q3.delete();
    tx_ready = 1'b1;
    enable = 1'b1;
    for (int s = 1; s <= 2; s++) begin
      pps3 = 1'b1;
      second = 16'(s);
      tick();
      pps3 = 1'b0;
      tick();
    end
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pps3 = 1'b1;
      pps = 1'b1;
      second = 16'h00AA;
      tick();
      pps3 = 1'b0;
      pps = 1'b0;
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      if (tx_valid || tx_valid3) seen++;
      tick();
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL enable_low pps: got %0d valid cycles exp 0", seen);
    end
    enable = 1'b1;
    pps3 = 1'b1;
    second = 16'h00C5;
    tick();
    pps3 = 1'b0;
    repeat (12) tick();
    n_tests++;
    if (q3.size() != FRAME_LEN) begin
      n_fail++;
      $display("FAIL enable div_cnt hold: got %0d bytes exp %0d", q3.size(), FRAME_LEN);
    end else begin
      n_tests++;
      if (q3[0] !== 8'h54 || q3[3] !== 8'h43 || q3[4] !== 8'h35) begin
        n_fail++;
        $display("FAIL enable frame C5: got %h %h %h exp 54 43 35", q3[0], q3[3], q3[4]);
      end
    end
    start_report(16'h00FF);
    enable = 1'b0;
    check_frame(mk(8'h54, 8'h30, 8'h30, 8'h46, 8'h46), 1'b0, "enable_drop_midframe");
    enable = 1'b1;
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    apply_reset();
    tx_ready = 1'b1;
    start_report(16'h0001);
    while (!(tx_valid && tx_data == 8'h0A) && cyc < 20) begin
      tick();
      cyc++;
    end
    n_tests++;
    if (cyc >= 20) begin
      n_fail++;
      $display("FAIL b2b LF timeout: got %0d cycles exp <20", cyc);
    end
    pps = 1'b1;
    second = 16'h2222;
    tick();
    n_tests++;
    if (busy !== 1'b0 || tx_valid !== 1'b0 || overrun_cnt !== 8'h01) begin
      n_fail++;
      $display("FAIL b2b LF-edge pps: got busy=%b valid=%b ovr=%h exp 0/0/01",
               busy, tx_valid, overrun_cnt);
    end
    second = 16'h3333;
    tick();
    pps = 1'b0;
    check_frame(mk(8'h54, 8'h33, 8'h33, 8'h33, 8'h33), 1'b0, "b2b_3333");
    n_tests++;
    if (overrun_cnt !== 8'h01) begin
      n_fail++;
      $display("FAIL b2b overrun final: got %h exp 01", overrun_cnt);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b1;
    pps      = 1'b0;
    pps3     = 1'b0;
    second   = 16'h0000;
    tx_ready = 1'b1;
    test_reset();
    test_frame();
    test_random_ready();
    test_div3();
    test_overrun();
    test_reset_mid();
    test_enable();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pps_uart_reporter.md
# pps_uart_reporter

Scheduler that sits between the one-second timer and the UART transmitter in the demo design. On every REPORT_DIV-th pulse-per-second strobe it snapshots the running second count and sequences an ASCII frame, one byte at a time, into the UART TX byte interface using a valid/ready handshake. Strobes that arrive while a frame is still in flight are counted as overruns rather than queued.

## Interface
Parameters:
- REPORT_DIV, 8'd1: report on every REPORT_DIV-th enabled pps. Legal range 1..255.
- HEADER_CHAR, 8'h54: first byte of every frame ('T').

Ports:
- clk_50m  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = pps strobes are honoured; 0 = pps ignored.
- pps  in  1  one-cycle strobe from the timer. `second` is already valid in the same cycle.
- second  in  16  running second count from the timer.
- tx_ready  in  1  UART accepts a byte at a rising edge when tx_valid && tx_ready.
- tx_data  out  8  byte offered to the UART.
- tx_valid  out  1  tx_data is valid.
- busy  out  1  a frame is in progress (state != IDLE).
- overrun_cnt  out  8  saturating count of dropped report strobes.

## Operation
- Frame format, uppercase hex, MSB nibble first: HEADER_CHAR, then four hex digits of the snapshot, then an optional CR (see Configuration), then LF (8'h0A).
- Hex digit encoding: 0–9 map to 8'h30–8'h39; A–F map to 8'h41–8'h46.
- Divider counter div_cnt (8 bit):
  - Increments on every cycle with pps && enable.
  - When div_cnt == REPORT_DIV-1 on such a cycle, the strobe is a "report strobe" and div_cnt returns to 0.
  - With REPORT_DIV = 1, every enabled pps is a report strobe.
- Report strobe in IDLE: latch `second` into a 16-bit snapshot register and go to HDR.
- Report strobe while busy:
  - overrun_cnt increments, saturating at 255.
  - The current frame is not disturbed and the snapshot is not overwritten.
- Non-report pps while busy: only div_cnt advances.
- States and transitions:
  - IDLE → HDR on a report strobe.
  - HDR → DIG on handshake.
  - DIG holds a 2-bit digit index 3..0 and advances on each handshake. After index 0 it goes to CR (macro defined) or LF.
  - CR → LF on handshake.
  - LF → IDLE on handshake.
- tx_valid = 1 in every state except IDLE.
- tx_data is a registered function of state, digit index and snapshot. It must be stable while tx_valid && !tx_ready.
- enable going low mid-frame does not abort the frame. It only blocks new pps from being honoured.
- Reset mid-frame: everything returns to reset values immediately. The partial frame is abandoned and no further bytes are offered.

## Timing
- Reset values: tx_data = 8'h00, tx_valid = 0, busy = 0, overrun_cnt = 0. Internally, div_cnt = 0, snapshot = 0, state = IDLE.
- Latency: a report strobe sampled at edge N gives tx_valid = 1 with tx_data = HEADER_CHAR from edge N through N+1. No combinational path from pps to tx_valid.
- Each byte advances on the edge where tx_valid && tx_ready. The next byte is presented in the following cycle.
- With tx_ready held high, the frame occupies 6 cycles (7 with CR). busy is high for exactly those cycles.
- Back-to-back: the earliest new report strobe that is accepted is the one sampled in the cycle after the LF handshake (state == IDLE).
- A pps sampled on the same edge as the LF handshake counts as an overrun.

## Configuration
- REPORTER_CRLF_EN:
  - Defined: insert CR (8'h0D) before LF. Frame = 7 bytes.
  - Undefined: the CR state is not compiled in, DIG index 0 goes directly to LF, and the frame = 6 bytes.

## Test plan
- Reset, tx_ready = 1, REPORT_DIV = 1, macro undefined; pps with second = 16'h1A2F → bytes 54,31,41,32,46,0A on 6 consecutive cycles; busy returns to 0 afterwards.
- Same stimulus with REPORTER_CRLF_EN defined and second = 16'h00FF → 54,30,30,46,46,0D,0A.
- tx_ready toggled pseudo-randomly → byte sequence unchanged; tx_data is constant whenever tx_valid && !tx_ready.
- REPORT_DIV = 3; six enabled pps carrying seconds 1..6 → exactly two frames, carrying 0003 and 0006.
- tx_ready = 0; 300 pps while the frame is stalled → overrun_cnt saturates at 255; releasing tx_ready completes the original frame with its original snapshot.
- reset_n pulsed low mid-digit; and enable = 0 during pps → all outputs at reset values with no bytes offered afterwards; a pps with enable = 0 produces no frame and leaves div_cnt unchanged.
